// File: rtl/and_gate_pkg.sv
// rtl/and_gate_pkg.sv - shared constants for the and_gate block
package and_gate_pkg;
  localparam int STAGES_MAX    = 8;
  localparam int WIDTH_DEFAULT = 1;
endpackage

// File: rtl/and_gate_stage.sv
// rtl/and_gate_stage.sv - WIDTH-wide D register with synchronous active-high clear
module and_gate_stage
  import and_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/and_gate.sv
// rtl/and_gate.sv - bitwise AND with combinational and pipelined registered outputs
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] x_q,
  output logic             all_q
);

  generate
    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("and_gate: STAGES out of range 1..STAGES_MAX");
    end
  endgenerate

  // chain[0] is the raw AND; chain[k] is the output of register stage k-1
  logic [WIDTH-1:0] chain [STAGES+1];

  assign x        = a & b;
  assign chain[0] = x;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      and_gate_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (chain[k]),
        .q   (chain[k+1])
      );
    end
  endgenerate

  assign x_q   = chain[STAGES];
  assign all_q = &x_q;

endmodule

// File: tb/tb_and_gate.sv
// tb/tb_and_gate.sv - directed self-checking bench for and_gate
module tb_and_gate;

  logic clk = 1'b0;
  logic rst;

  logic       a1, b1, x1, xq1, all1;
  logic [7:0] a8, b8, x8, xq8;
  logic       all8;
  logic       a2, b2, x2, xq2, all2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1), .STAGES(1)) u_w1s1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .x(x1), .x_q(xq1), .all_q(all1)
  );

  and_gate #(.WIDTH(8), .STAGES(3)) u_w8s3 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .x(x8), .x_q(xq8), .all_q(all8)
  );

  and_gate #(.WIDTH(1), .STAGES(2)) u_w1s2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .x(x2), .x_q(xq2), .all_q(all2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  logic [1:0] vec_ab [4];
  logic       vec_x  [4];
  logic       seq    [5];

  initial begin
    vec_ab[0] = 2'b00; vec_x[0] = 1'b0;
    vec_ab[1] = 2'b10; vec_x[1] = 1'b0;
    vec_ab[2] = 2'b11; vec_x[2] = 1'b1;
    vec_ab[3] = 2'b01; vec_x[3] = 1'b0;
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b0; seq[4] = 1'b0;

    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    a2 = 1'b0; b2 = 1'b0;
    edges(2);
    check("reset_xq1",   8'(xq1),  8'h00);
    check("reset_all1",  8'(all1), 8'h00);
    check("reset_xq8",   xq8,      8'h00);
    check("reset_all8",  8'(all8), 8'h00);
    check("reset_xq2",   8'(xq2),  8'h00);
    @(negedge clk);
    rst = 1'b0;

    // truth table on WIDTH=1, STAGES=1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = vec_ab[i][1];
      b1 = vec_ab[i][0];
      #1;
      check($sformatf("tt_x_%0d", i), 8'(x1), 8'(vec_x[i]));
      edges(1);
      check($sformatf("tt_xq_%0d", i), 8'(xq1), 8'(vec_x[i]));
      repeat (9) @(posedge clk);
    end

    // reset mid-stream
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    edges(1);
    check("mid_xq_before", 8'(xq1), 8'h01);
    check("mid_all_before", 8'(all1), 8'h01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_x_during", 8'(x1), 8'h01);
    edges(1);
    check("mid_xq_after",  8'(xq1),  8'h00);
    check("mid_all_after", 8'(all1), 8'h00);
    check("mid_x_after",   8'(x1),   8'h01);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=8, STAGES=3 latency
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h3C;
    #1;
    check("w8_x", x8, 8'h30);
    edges(2);
    check("w8_xq_edge2", xq8, 8'h00);
    edges(1);
    check("w8_xq_edge3", xq8, 8'h30);
    check("w8_all_30", 8'(all8), 8'h00);

    // all_q reduction
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    edges(3);
    check("w8_xq_ff",  xq8,      8'hFF);
    check("w8_all_ff", 8'(all8), 8'h01);
    @(negedge clk);
    b8 = 8'hFE;
    edges(2);
    check("w8_all_hold", 8'(all8), 8'h01);
    edges(1);
    check("w8_all_drop", 8'(all8), 8'h00);
    check("w8_xq_fe",    xq8,      8'hFE);

    // back-to-back on STAGES=2
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a2 = seq[i]; b2 = 1'b1;
      edges(1);
      if (i >= 1) check($sformatf("b2b_%0d", i), 8'(xq2), 8'(seq[i-1]));
    end

    // simultaneous reset and input change
    @(negedge clk);
    rst = 1'b1;
    a8 = 8'h0F; b8 = 8'hFF;
    edges(1);
    check("sim_xq_rst", xq8, 8'h00);
    check("sim_x_rst",  x8,  8'h0F);
    @(negedge clk);
    rst = 1'b0;
    edges(2);
    check("sim_xq_rel2", xq8, 8'h00);
    edges(1);
    check("sim_xq_rel3", xq8, 8'h0F);
    check("sim_all_rel3", 8'(all8), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
